im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 Parameter SYNC, default 8'hA5, start-of-image sync byte.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 byte_valid  input  1  upstream byte present.
REQ-006 byte_data  input  8  upstream byte.
REQ-007 byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready.
REQ-008 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 im_addr  output  ADDR_W  word address of write.
REQ-010 im_d  output  32  instruction word written.
REQ-011 cpu_hold  output  1  holds CPU (PC and register writes frozen) while 1.
REQ-012 done  output  1  image fully loaded.
REQ-013 err  output  1  sticky overflow error.

Function
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE.
REQ-015 IDLE: byte_ready=1; transfer of SYNC -> LEN_HI; any other byte is discarded, state unchanged.
REQ-016 LEN_HI: transfer loads count[15:8] -> LEN_LO; LEN_LO: transfer loads count[7:0], clears word index and err.
REQ-017 LEN_LO exit: count==0 -> DONE; else -> DATA.
REQ-018 DATA: byte_ready=1; bytes assemble big-endian (first byte = im_d[31:24]); byte counter 0..3.
REQ-019 4th byte transfer -> WRITE next cycle with im_d holding the assembled word.
REQ-020 WRITE: byte_ready=0; im_we=1 for exactly this cycle; im_addr = current word index; word index increments at end of cycle.
REQ-021 WRITE exit: words written == count -> DONE; else -> DATA.
REQ-022 Latency: im_we asserts exactly 1 cycle after the 4th byte transfer; sustained input gives 1 word per 5 cycles.
REQ-023 Overflow: word index >= 2^ADDR_W -> im_we SHALL stay 0 in WRITE, err set (sticky until next LEN_LO); word still consumed and counted.
REQ-024 im_addr SHALL NOT wrap to 0 on overflow (no overwrite of word 0).
REQ-025 cpu_hold=1 in all states except DONE; done=1 only in DONE.
REQ-026 DONE: byte_ready=1; transfer of SYNC -> LEN_HI (cpu_hold reasserts next cycle); other bytes discarded.
REQ-027 byte_valid deasserted mid-word SHALL stall assembly with no loss; partial word retained indefinitely.
REQ-028 byte_data SHALL be ignored in any cycle where byte_ready=0.
REQ-029 im_we, im_addr, im_d, byte_ready, cpu_hold, done SHALL be driven from registers or state decode only (no combinational path from byte_valid/byte_data).

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, im_we=0, im_addr=0, im_d=0, count=0, byte counter=0, cpu_hold=1, done=0, err=0.
REQ-031 byte_ready SHALL be 1 (IDLE) from the first clock after rst_n rises.
REQ-032 Reset mid-image SHALL abandon the partial word with no further im_we; image must restart from SYNC.

Verification
REQ-033 Stream A5 00 02 20 04 00 07 20 05 00 03 -> im_we at addr 0 with 32'h20040007, addr 1 with 32'h20050003; done=1, cpu_hold=0 after second write.
REQ-034 Stream A5 00 00 -> DONE with zero im_we pulses; done=1 the cycle after LEN_LO transfer.
REQ-035 Bytes 00 FF then A5 00 01 + 4 bytes -> leading 00 FF ignored; one write at addr 0.
REQ-036 ADDR_W=2, count=5 -> writes addr 0..3 only; 5th word consumed with im_we=0; err=1, done=1.
REQ-037 byte_valid toggled randomly during a 3-word image -> identical memory contents and addresses to back-to-back case.
REQ-038 rst_n pulsed low after 2 data bytes of word 1, then full 1-word image -> no write from aborted word; single write at addr 0; in DONE, new SYNC reasserts cpu_hold.

Source files
------------

// File: rtl/im_loader.sv
// Instruction-memory boot loader.
// Waits for a sync byte, reads a 16-bit big-endian word count, then assembles
// big-endian 32-bit words from the byte stream and writes them to consecutive
// instruction-memory addresses while holding the CPU. Words beyond the memory
// depth are consumed and counted but never written, and raise a sticky error.
module im_loader #(
    parameter int          ADDR_W = 8,      // word-address width, 1..16
    parameter logic [7:0]  SYNC   = 8'hA5   // start-of-image marker
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_d,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Word index is one bit wider than the 16-bit count so that the
    // out-of-range test below never aliases for any legal ADDR_W.
    localparam int IDX_W = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic               im_we_q, im_we_d;
    logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [31:0]        im_d_q, im_d_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               in_range;
    logic               is_sync;
    logic [15:0]        len_full;
    logic [IDX_W-1:0]   idx_inc;

    // byte_ready is a pure decode of the state register: the only cycle
    // that refuses bytes is the one-cycle memory write slot.
    assign byte_ready = (state_q != S_WRITE);
    assign xfer       = byte_valid & byte_ready;
    assign is_sync    = (byte_data == SYNC);
    assign len_full   = {count_q[15:8], byte_data};
    assign idx_inc    = idx_q + IDX_W'(1);
    // Current word index still addresses a real memory location.
    assign in_range   = ((idx_q >> ADDR_W) == '0);

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_d     = im_d_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

    // Next-state and next-output computation for the loader FSM.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_d_d     = im_d_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (xfer && is_sync) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    count_d[15:8] = byte_data;
                    state_d       = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    count_d = len_full;
                    idx_d   = '0;
                    bcnt_d  = 2'd0;
                    err_d   = 1'b0;
                    state_d = (len_full == 16'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // Shifting left places the first byte in bits 31:24.
                    im_d_d = {im_d_q[23:0], byte_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        if (in_range) begin
                            im_we_d   = 1'b1;
                            im_addr_d = idx_q[ADDR_W-1:0];
                        end else begin
                            // Address is held, not wrapped, so word 0 survives.
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == {1'b0, count_q}) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                if (xfer && is_sync) begin
                    state_d = S_LEN_HI;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags follow the next state so they are valid in the same
    // cycle the FSM occupies DONE.
    always_comb begin
        done_d     = (state_d == S_DONE);
        cpu_hold_d = ~done_d;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_d_q     <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_d_q     <= im_d_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: two instances (depth 256 and depth 4)
// share one byte stream; writes are captured and compared with expectations.
module tb_im_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;

    logic        br8, we8, hold8, done8, err8;
    logic [7:0]  a8;
    logic [31:0] d8;
    logic        br2, we2, hold2, done2, err2;
    logic [1:0]  a2;
    logic [31:0] d2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] wq8[$];
    logic [63:0] wq2[$];
    int          cq8[$];
    logic [31:0] exp_words[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    im_loader #(.ADDR_W(8), .SYNC(SYNC)) dut8 (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(br8), .im_we(we8), .im_addr(a8), .im_d(d8),
        .cpu_hold(hold8), .done(done8), .err(err8)
    );

    im_loader #(.ADDR_W(2), .SYNC(SYNC)) dut2 (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(br2), .im_we(we2), .im_addr(a2), .im_d(d2),
        .cpu_hold(hold2), .done(done2), .err(err2)
    );

    // Capture every write strobe mid-cycle.
    always @(negedge clk) begin
        if (we8) begin
            wq8.push_back({32'(a8), d8});
            cq8.push_back(cyc);
        end
        if (we2) wq2.push_back({32'(a2), d2});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_caps();
        wq8.delete();
        wq2.delete();
        cq8.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int  waited;
        logic rdy;
        waited = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            rdy = br8;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_byte_timeout: byte %h never accepted", b);
                break;
            end
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    // Randomly idles before offering a byte; data bus carries junk while idle.
    task automatic send_rnd(input logic [7:0] b);
        int gaps;
        gaps = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        repeat (gaps) begin
            byte_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        send_byte(b);
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we8", we8, 0);
        chk("rst_addr8", a8, 0);
        chk("rst_d8", d8, 0);
        chk("rst_hold8", hold8, 1);
        chk("rst_done8", done8, 0);
        chk("rst_err8", err8, 0);
        chk("rst_err2", err2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready8", br8, 1);
        clear_caps();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 10; i++) begin
            if (done8 && done2) break;
            @(posedge clk);
            #1;
        end
    endtask

    // Compare captured writes and flags against exp_words for both depths.
    task automatic check_image(input string tag, input logic exp_e2, input logic chk_addr);
        int n, n2;
        n  = exp_words.size();
        n2 = (n > 4) ? 4 : n;
        chk({tag, "_nw8"}, wq8.size(), n);
        for (int i = 0; i < n && i < wq8.size(); i++) begin
            chk($sformatf("%s_w8_%0d", tag, i), wq8[i][31:0], exp_words[i]);
            chk($sformatf("%s_a8_%0d", tag, i), wq8[i][63:32], i);
        end
        chk({tag, "_nw2"}, wq2.size(), n2);
        for (int i = 0; i < n2 && i < wq2.size(); i++) begin
            chk($sformatf("%s_w2_%0d", tag, i), wq2[i][31:0], exp_words[i]);
            chk($sformatf("%s_a2_%0d", tag, i), wq2[i][63:32], i);
        end
        chk({tag, "_done8"}, done8, 1);
        chk({tag, "_hold8"}, hold8, 0);
        chk({tag, "_err8"}, err8, 0);
        chk({tag, "_done2"}, done2, 1);
        chk({tag, "_hold2"}, hold2, 0);
        chk({tag, "_err2"}, err2, exp_e2);
        if (chk_addr && n > 0) begin
            chk({tag, "_lastaddr8"}, a8, n - 1);
            chk({tag, "_lastaddr2"}, a2, n2 - 1);
        end
        clear_caps();
    endtask

    typedef struct packed {
        logic [255:0] bytes;   // right-aligned, first byte most significant
        logic [7:0]   len;
        logic [191:0] words;   // right-aligned, first word most significant
        logic [3:0]   nw;
        logic         err2;
    } vec_t;

    vec_t        vecs[6];
    vec_t        cur;
    int          nw_r, junk;
    logic [7:0]  b;
    logic [31:0] w;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{bytes: 256'({8'hA5, 8'h00, 8'h02, 32'h20040007, 32'h20050003}),
                    len: 8'd11, words: 192'({32'h20040007, 32'h20050003}), nw: 4'd2, err2: 1'b0};
        vecs[1] = '{bytes: 256'({8'hA5, 8'h00, 8'h00}),
                    len: 8'd3, words: '0, nw: 4'd0, err2: 1'b0};
        vecs[2] = '{bytes: 256'({8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 32'hDEADBEEF}),
                    len: 8'd9, words: 192'(32'hDEADBEEF), nw: 4'd1, err2: 1'b0};
        vecs[3] = '{bytes: 256'({8'hA5, 8'h00, 8'h05, 32'h11111111, 32'h22222222,
                                 32'h33333333, 32'h44444444, 32'h55555555}),
                    len: 8'd23,
                    words: 192'({32'h11111111, 32'h22222222, 32'h33333333,
                                 32'h44444444, 32'h55555555}),
                    nw: 4'd5, err2: 1'b1};
        vecs[4] = '{bytes: 256'({8'hA5, 8'h00, 8'h01, 32'hA5A5A5A5}),
                    len: 8'd7, words: 192'(32'hA5A5A5A5), nw: 4'd1, err2: 1'b0};
        vecs[5] = '{bytes: 256'({8'h12, 8'hA5, 8'h00, 8'h03, 32'h00000000,
                                 32'hFFFFFFFF, 32'h80000001}),
                    len: 8'd16,
                    words: 192'({32'h00000000, 32'hFFFFFFFF, 32'h80000001}),
                    nw: 4'd3, err2: 1'b0};

        // Table-driven images, each from reset, bytes back to back.
        for (int v = 0; v < 6; v++) begin
            cur = vecs[v];
            do_reset();
            for (int i = 0; i < int'(cur.len); i++)
                send_byte(cur.bytes[8*(int'(cur.len) - 1 - i) +: 8]);
            wait_done();
            exp_words.delete();
            for (int k = 0; k < int'(cur.nw); k++)
                exp_words.push_back(cur.words[32*(int'(cur.nw) - 1 - k) +: 32]);
            check_image($sformatf("vec%0d", v), cur.err2, 1'b1);
            $display("vector %0d: %0d bytes, %0d words checked", v, cur.len, cur.nw);
        end

        // Write latency and throughput with sustained input.
        do_reset();
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("lat_we_first", we8, 1);
        chk("lat_d_first", d8, 32'h01020304);
        chk("lat_addr_first", a8, 0);
        chk("lat_ready_in_write", br8, 0);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        chk("lat_we_second", we8, 1);
        chk("lat_d_second", d8, 32'h05060708);
        chk("lat_addr_second", a8, 1);
        @(posedge clk); #1;
        chk("lat_done", done8, 1);
        chk("lat_nwrites", cq8.size(), 2);
        if (cq8.size() == 2) chk("lat_spacing", cq8[1] - cq8[0], 5);
        $display("latency sequence: writes=%0d", cq8.size());

        // Count of zero: done the cycle after the low length byte.
        do_reset();
        send_byte(SYNC); send_byte(8'h00);
        chk("zero_hold_before", hold8, 1);
        send_byte(8'h00);
        chk("zero_done_next", done8, 1);
        chk("zero_nwrites", wq8.size(), 0);
        $display("zero-length sequence checked");

        // Reset mid-word abandons the partial word; DONE accepts a new SYNC.
        do_reset();
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        wait_done();
        exp_words.delete();
        exp_words.push_back(32'hCAFEBABE);
        check_image("abort", 1'b0, 1'b1);
        send_byte(8'h3C);
        chk("done_junk_hold", hold8, 0);
        send_byte(SYNC);
        chk("resync_hold", hold8, 1);
        chk("resync_done", done8, 0);
        send_byte(8'h00); send_byte(8'h00);
        chk("resync_done_again", done8, 1);
        $display("abort/resync sequence checked");

        // Randomized chained images against the reference rules.
        do_reset();
        for (int it = 0; it < 25; it++) begin
            nw_r = int'($urandom_range(0, 6));
            junk = int'($urandom_range(0, 2));
            exp_words.delete();
            for (int j = 0; j < junk; j++) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h5A;
                send_rnd(b);
            end
            send_rnd(SYNC);
            send_rnd(8'h00);
            send_rnd(8'(nw_r));
            for (int k = 0; k < nw_r; k++) begin
                w = $urandom;
                exp_words.push_back(w);
                for (int s = 3; s >= 0; s--) send_rnd(w[8*s +: 8]);
            end
            wait_done();
            check_image($sformatf("rnd%0d", it), nw_r > 4, 1'b1);
            $display("random image %0d: %0d words, %0d junk bytes", it, nw_r, junk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
